// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped read-only instruction cache between the IFU fetch port and AXI.
// A miss refills the whole line with one INCR burst; fence_i invalidates every line.
module ysyx_23060025_icache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_psel,
    input  logic [ADDR_WIDTH-1:0] in_paddr,
    output logic                  in_pready,
    output logic [DATA_WIDTH-1:0] in_prdata,
    input  logic                  fence_i,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast
);
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int WORD_BITS = OFFSET_BITS - 2;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int WORDS     = 1 << WORD_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, ADDR, REFILL, RESP} state_t;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [WORD_BITS-1:0]    beat_cnt;
    logic [DATA_WIDTH-1:0]   resp_buf;
    logic                    err;
    logic                    fence_pending;
    logic [LINES-1:0]        valid;
    logic [TAG_BITS-1:0]     tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]   data_mem [LINES][WORDS];

    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [WORD_BITS-1:0]    req_word;
    logic                    hit;
    logic                    beat_fire;
    logic                    beat_err;
    logic                    to_idle;
    logic                    unused_addr_bits;

    assign req_tag          = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_idx          = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_word         = req_addr[2 +: WORD_BITS];
    assign unused_addr_bits = ^req_addr[1:0];
    assign hit              = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign beat_fire        = (state == REFILL) && axi_rvalid;
    assign beat_err         = (axi_rresp != 2'b00);
    assign to_idle          = (state != IDLE) && (next_state == IDLE);

    assign axi_arlen   = 8'(WORDS - 1);
    assign axi_arsize  = 3'b010;
    assign axi_arburst = 2'b01;

    always_comb begin
        next_state  = state;
        in_pready   = 1'b0;
        in_prdata   = '0;
        axi_arvalid = 1'b0;
        axi_araddr  = '0;
        axi_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (!fence_i && in_psel) next_state = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    in_pready  = 1'b1;
                    in_prdata  = data_mem[req_idx][req_word];
                    next_state = IDLE;
                end else begin
                    next_state = ADDR;
                end
            end
            ADDR: begin
                axi_arvalid = 1'b1;
                axi_araddr  = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
                if (axi_arready) next_state = REFILL;
            end
            REFILL: begin
                axi_rready = 1'b1;
                if (axi_rvalid && axi_rlast) next_state = RESP;
            end
            RESP: begin
                in_pready  = 1'b1;
                in_prdata  = resp_buf;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A fence seen mid-transaction is deferred and applied as the FSM re-enters IDLE,
    // so the in-flight response is still delivered but the next request misses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            req_addr      <= '0;
            beat_cnt      <= '0;
            resp_buf      <= '0;
            err           <= 1'b0;
            fence_pending <= 1'b0;
            valid         <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (in_psel && !fence_i) req_addr <= in_paddr;
                end
                ADDR: beat_cnt <= '0;
                REFILL: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + WORD_BITS'(1);
                        if (beat_cnt == req_word) resp_buf <= axi_rdata;
                        if (beat_err) err <= 1'b1;
                        if (axi_rlast)
                            valid[req_idx] <= !(err || beat_err || fence_pending || fence_i);
                    end
                end
                RESP: err <= 1'b0;
                default: ;
            endcase
            if (state != IDLE && fence_i) fence_pending <= 1'b1;
            if ((state == IDLE && fence_i) || (to_idle && (fence_pending || fence_i))) begin
                valid         <= '0;
                fence_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && beat_fire) begin
            data_mem[req_idx][beat_cnt] <= axi_rdata;
            if (axi_rlast) tag_mem[req_idx] <= req_tag;
        end
    end
endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Randomized bench for ysyx_23060025_icache: a fixed memory image, an AXI read slave,
// and a line-level model of which lines are resident.
module tb_ysyx_23060025_icache;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_psel;
    logic [31:0] in_paddr;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        fence_i;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;

    int checks = 0;
    int errors = 0;

    logic        model_valid [16];
    logic [23:0] model_tag   [16];

    ysyx_23060025_icache dut (
        .clock       (clock),
        .reset       (reset),
        .in_psel     (in_psel),
        .in_paddr    (in_paddr),
        .in_pready   (in_pready),
        .in_prdata   (in_prdata),
        .fence_i     (fence_i),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h3000000) return 32'h11 * {30'd0, a[3:2]} + 32'h11;
        return (a * 32'h9E3779B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
    endtask

    // One fetch with an AXI slave in the loop. fence_at/reset_at are cycle numbers
    // counted from the request being driven (-1 = never).
    task automatic applyStimulus(input logic [31:0] addr, input int ar_delay, input int gap_pct,
                                 input int err_beat, input int fence_at, input int reset_at);
        logic [3:0]  idx;
        logic [23:0] tg;
        logic [31:0] line;
        logic [31:0] got;
        logic        exp_hit, fence_fired, done, ar_done, prev_arvalid, prev_rready;
        int          cycles, ar_wait, beats, first_ar, last_beat_cycle;
        idx = addr[7:4];
        tg = addr[31:8];
        line = {addr[31:4], 4'h0};
        got = '0;
        fence_fired = 1'b0;
        done = 1'b0;
        ar_done = 1'b0;
        prev_arvalid = 1'b0;
        prev_rready = 1'b0;
        cycles = 0;
        ar_wait = 0;
        beats = 0;
        first_ar = -1;
        last_beat_cycle = -1;

        @(negedge clock);
        in_psel = 1'b1;
        in_paddr = addr;
        axi_arready = 1'b0;
        axi_rvalid = 1'b0;
        fence_i = (fence_at == 0);
        if (fence_at == 0) clearModel();
        exp_hit = model_valid[idx] && (model_tag[idx] == tg);

        while (!done && cycles < 200) begin
            @(negedge clock);
            cycles++;
            fence_i = 1'b0;
            if (axi_arready && prev_arvalid) ar_done = 1'b1;
            if (axi_rvalid && prev_rready) begin
                beats++;
                if (axi_rlast) last_beat_cycle = cycles;
                axi_rvalid = 1'b0;
            end
            axi_arready = 1'b0;
            if (cycles == reset_at) begin
                checkOutput("rready_before_reset", 32'(axi_rready), 32'd1);
                reset = 1'b1;
                in_psel = 1'b0;
                @(negedge clock);
                checkOutput("rst_pready", 32'(in_pready), 32'd0);
                checkOutput("rst_prdata", in_prdata, 32'd0);
                checkOutput("rst_arvalid", 32'(axi_arvalid), 32'd0);
                checkOutput("rst_rready", 32'(axi_rready), 32'd0);
                checkOutput("rst_araddr", axi_araddr, 32'd0);
                reset = 1'b0;
                clearModel();
                return;
            end
            if (in_pready) begin
                done = 1'b1;
                got = in_prdata;
                in_psel = 1'b0;
            end else begin
                checkOutput("prdata_when_not_ready", in_prdata, 32'd0);
            end
            if (axi_arvalid) begin
                if (first_ar < 0) begin
                    first_ar = cycles;
                    checkOutput("ar_ctrl", {19'd0, axi_arlen, axi_arsize, axi_arburst},
                                {19'd0, 8'd3, 3'b010, 2'b01});
                end
                checkOutput("araddr", axi_araddr, line);
                if (ar_wait >= ar_delay) axi_arready = 1'b1;
                ar_wait++;
            end
            prev_arvalid = axi_arvalid;
            prev_rready = axi_rready;
            if (ar_done && !axi_rvalid && beats < 4 && !done && $urandom_range(99) >= gap_pct) begin
                axi_rvalid = 1'b1;
                axi_rdata = mem_word(line + 32'(4 * beats));
                axi_rresp = (beats == err_beat) ? 2'b10 : 2'b00;
                axi_rlast = (beats == 3);
            end
            if (fence_at > 0 && cycles == fence_at) begin
                fence_i = 1'b1;
                fence_fired = 1'b1;
            end
        end

        checkOutput("response_seen", 32'(done), 32'd1);
        if (done) begin
            checkOutput("prdata", got, mem_word(addr));
            checkOutput("hit_no_ar", 32'(first_ar < 0), 32'(exp_hit));
            if (exp_hit) begin
                checkOutput("hit_latency", cycles, 1);
            end else begin
                checkOutput("ar_latency", first_ar, 2 + ((fence_at == 0) ? 1 : 0));
                checkOutput("beats", beats, 4);
                checkOutput("resp_latency", cycles, last_beat_cycle);
                model_valid[idx] = (err_beat < 0 || err_beat > 3);
                model_tag[idx] = tg;
            end
        end
        if (fence_fired) clearModel();
    endtask

    initial begin
        logic [31:0] a;
        int          eb, fa;
        reset = 1'b1;
        in_psel = 1'b0;
        in_paddr = '0;
        fence_i = 1'b0;
        axi_arready = 1'b0;
        axi_rvalid = 1'b0;
        axi_rdata = '0;
        axi_rresp = 2'b00;
        axi_rlast = 1'b0;
        clearModel();
        for (int i = 0; i < 16; i++) model_tag[i] = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset_pready", 32'(in_pready), 32'd0);
        checkOutput("reset_prdata", in_prdata, 32'd0);
        checkOutput("reset_arvalid", 32'(axi_arvalid), 32'd0);
        checkOutput("reset_rready", 32'(axi_rready), 32'd0);
        checkOutput("reset_araddr", axi_araddr, 32'd0);
        reset = 1'b0;

        applyStimulus(32'h3000_0004, 0, 0, -1, -1, -1);
        applyStimulus(32'h3000_000C, 0, 0, -1, -1, -1);
        applyStimulus(32'h3000_0100, 0, 0, -1, -1, -1);
        applyStimulus(32'h3000_0000, 0, 0, -1, -1, -1);
        applyStimulus(32'h3000_0214, 0, 0, 1, -1, -1);
        applyStimulus(32'h3000_0214, 0, 0, -1, -1, -1);
        applyStimulus(32'h3000_0040, 0, 0, -1, 4, -1);
        applyStimulus(32'h3000_0040, 0, 0, -1, -1, -1);
        applyStimulus(32'h3000_0080, 0, 0, -1, -1, -1);
        applyStimulus(32'h3000_0080, 0, 0, -1, 0, -1);
        applyStimulus(32'h3000_0084, 0, 0, -1, 1, -1);
        applyStimulus(32'h3000_0088, 0, 0, -1, -1, -1);
        applyStimulus(32'h3000_0300, 5, 40, -1, -1, -1);
        applyStimulus(32'h3000_0304, 0, 0, -1, -1, -1);
        applyStimulus(32'h3000_0400, 0, 0, -1, -1, 4);
        applyStimulus(32'h3000_0300, 0, 0, -1, -1, -1);

        for (int n = 0; n < 200; n++) begin
            a = {24'h300000 + 24'($urandom_range(2)), 4'($urandom_range(15)),
                 2'($urandom_range(3)), 2'b00};
            eb = ($urandom_range(9) == 0) ? int'($urandom_range(3)) : -1;
            fa = ($urandom_range(19) == 0) ? int'($urandom_range(6)) : -1;
            applyStimulus(a, int'($urandom_range(3)), int'($urandom_range(50)), eb, fa, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
